wb_bus_decoder: RTL and testbench

Parametrised Wishbone address decoder and response router between the CPU memory port and up to NSLAVES slaves, such as the memory controller, UART and timer. It decodes each request against a base/mask address map, forwards it to exactly one slave, and tracks the single outstanding transaction. It returns a registered ack with data, or a registered error for unmapped addresses and, optionally, for slave timeouts.

---
 rtl/wb_bus_decoder.sv | 147 ++++++++++++++
 tb/tb_wb_bus_decoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_decoder.sv
// Wishbone address decoder / response router for up to NSLAVES slaves with one outstanding transaction.
// Define WB_BUS_TIMEOUT_EN to add the BUSY timeout counter and timeout error.
module wb_bus_decoder #(
  parameter int                    NSLAVES        = 2,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE     = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK     = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [31:0]             i_wb_addr,
  input  logic [31:0]             i_wb_data,
  input  logic [2:0]              i_wb_sel,
  output logic [31:0]             o_wb_data,
  output logic                    o_wb_ack,
  output logic                    o_wb_err,
  output logic                    o_wb_stall,
  output logic [NSLAVES-1:0]      o_s_stb,
  output logic                    o_s_we,
  output logic [31:0]             o_s_addr,
  output logic [31:0]             o_s_data,
  output logic [2:0]              o_s_sel,
  input  logic [NSLAVES*32-1:0]   i_s_data,
  input  logic [NSLAVES-1:0]      i_s_ack,
  input  logic [NSLAVES-1:0]      i_s_stall
);

  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t        state;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_q;
  logic          hit;
  logic [31:0]   mask_sel;
  logic [31:0]   rdata_sel;
  logic          timeout_hit;

  // Descending scan so the lowest matching index is the last one written.
  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    mask_sel = SLAVE_MASK[31:0];
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      if ((i_wb_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
        hit      = 1'b1;
        sel      = SW'(k);
        mask_sel = SLAVE_MASK[32*k +: 32];
      end
    end
  end

  // Reset gates the combinational handshake so it drops the instant reset asserts.
  always_comb begin
    o_wb_stall = 1'b0;
    o_s_stb    = '0;
    if (i_reset) begin
      if (state == IDLE) begin
        if (hit) begin
          o_wb_stall   = i_s_stall[sel];
          o_s_stb[sel] = i_wb_stb;
        end
      end else begin
        o_wb_stall = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_sel = i_s_data[31:0];
    for (int k = 1; k < NSLAVES; k++) begin
      if (sel_q == SW'(k)) rdata_sel = i_s_data[32*k +: 32];
    end
  end

  assign o_s_we   = i_wb_we;
  assign o_s_addr = i_wb_addr & ~mask_sel;
  assign o_s_data = i_wb_data;
  assign o_s_sel  = i_wb_sel;

`ifdef WB_BUS_TIMEOUT_EN
  logic [7:0] cnt;

  // cnt holds the number of completed BUSY cycles, so the error lands at T+TIMEOUT_CYCLES+1.
  assign timeout_hit = (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (state != BUSY) begin
      cnt <= '0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  // NOTE: registered state uses nonblocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= 32'hFFFF_FFFF;
    end else begin
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= 32'hFFFF_FFFF;
      case (state)
        IDLE: begin
          if (i_wb_stb && !o_wb_stall) begin
            if (hit) begin
              sel_q <= sel;
              state <= BUSY;
            end else begin
              // Unmapped: the error pulse coincides with the single ERR cycle.
              o_wb_err <= 1'b1;
              state    <= ERR;
            end
          end
        end
        BUSY: begin
          if (i_s_ack[sel_q]) begin
            o_wb_ack  <= 1'b1;
            o_wb_data <= rdata_sel;
            state     <= IDLE;
          end else if (timeout_hit) begin
            o_wb_err <= 1'b1;
            state    <= IDLE;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Scoreboard bench for wb_bus_decoder: stimulus pushes expected responses, a monitor pops them on ack/err.
module tb_wb_bus_decoder;

  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_stb, wb_we;
  logic [31:0]     wb_addr, wb_wdata;
  logic [2:0]      wb_sel;
  logic [31:0]     wb_data;
  logic            wb_ack, wb_err, wb_stall;
  logic [NS-1:0]   s_stb;
  logic            s_we;
  logic [31:0]     s_addr, s_data;
  logic [2:0]      s_sel;
  logic [NS*32-1:0] s_rdata;
  logic [NS-1:0]   s_ack, s_stall;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0;

  wb_bus_decoder #(
    .NSLAVES       (NS),
    .SLAVE_BASE    ({32'h2000_0000, 32'h0000_0100, 32'h0000_0000}),
    .SLAVE_MASK    ({32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_wb_stb  (wb_stb),
    .i_wb_we   (wb_we),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_wdata),
    .i_wb_sel  (wb_sel),
    .o_wb_data (wb_data),
    .o_wb_ack  (wb_ack),
    .o_wb_err  (wb_err),
    .o_wb_stall(wb_stall),
    .o_s_stb   (s_stb),
    .o_s_we    (s_we),
    .o_s_addr  (s_addr),
    .o_s_data  (s_data),
    .o_s_sel   (s_sel),
    .i_s_data  (s_rdata),
    .i_s_ack   (s_ack),
    .i_s_stall (s_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic is_err, input logic [31:0] data, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_wdata = '0;
    wb_sel   = 3'b010;
    s_ack    = '0;
    s_stall  = '0;
  endtask

  // Monitor: every ack/err must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (rst_n && (wb_ack || wb_err)) begin
      exp_t e;
      check("ack_err_exclusive", {31'b0, wb_ack & wb_err}, 32'd0);
      check("resp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("resp_is_err", {31'b0, wb_err}, {31'b0, e.is_err});
        check("resp_data", wb_data, e.data);
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    idle_inputs();
    s_rdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    // Reset with a stalled, strobed request present: handshake outputs must still be idle.
    wb_stb  = 1'b1;
    wb_addr = 32'h0000_0010;
    s_stall = 3'b001;
    sample();
    check("rst_ack", {31'b0, wb_ack}, 32'd0);
    check("rst_err", {31'b0, wb_err}, 32'd0);
    check("rst_data", wb_data, 32'hFFFF_FFFF);
    check("rst_stall", {31'b0, wb_stall}, 32'd0);
    check("rst_s_stb", {29'b0, s_stb}, 32'd0);
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();

    // Read 0x10, slave0 acks at T+3.
    wb_stb = 1'b1; wb_addr = 32'h0000_0010; wb_sel = 3'b101;
    t0 = cyc;
    push(1'b0, 32'hDEAD_BEEF, t0 + 4);
    sample();
    check("rd_s_stb", {29'b0, s_stb}, 32'b001);
    check("rd_stall_T", {31'b0, wb_stall}, 32'd0);
    check("rd_s_addr", s_addr, 32'h0000_0010);
    check("rd_s_sel", {29'b0, s_sel}, 32'b101);
    step();
    wb_stb = 1'b0;
    sample();
    check("rd_stall_T1", {31'b0, wb_stall}, 32'd1);
    check("rd_s_stb_T1", {29'b0, s_stb}, 32'd0);
    check("rd_idle_data", wb_data, 32'hFFFF_FFFF);
    step();
    sample();
    check("rd_stall_T2", {31'b0, wb_stall}, 32'd1);
    step();
    s_ack   = 3'b001;
    s_rdata = {32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF};
    sample();
    check("rd_stall_T3", {31'b0, wb_stall}, 32'd1);
    step();
    s_ack = '0;
    sample();
    check("rd_stall_T4", {31'b0, wb_stall}, 32'd0);
    step();

    // Unmapped read: error at T+1, no strobe.
    wb_stb = 1'b1; wb_addr = 32'h8000_0000;
    t0 = cyc;
    push(1'b1, 32'hFFFF_FFFF, t0 + 1);
    sample();
    check("unm_s_stb", {29'b0, s_stb}, 32'd0);
    check("unm_stall", {31'b0, wb_stall}, 32'd0);
    step();
    wb_stb = 1'b0;
    step();
    step();

    // Overlapping map write at 0x100: slave0 wins; spurious slave1 ack ignored.
    wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 32'h0000_0100;
    wb_wdata = 32'h1234_5678; wb_sel = 3'b010;
    t0 = cyc;
    push(1'b0, 32'hCAFE_0001, t0 + 3);
    sample();
    check("ovl_s_stb", {29'b0, s_stb}, 32'b001);
    check("ovl_s_addr", s_addr, 32'h0000_0100);
    check("ovl_s_we", {31'b0, s_we}, 32'd1);
    check("ovl_s_data", s_data, 32'h1234_5678);
    check("ovl_s_sel", {29'b0, s_sel}, 32'b010);
    step();
    wb_stb = 1'b0; wb_we = 1'b0;
    s_ack   = 3'b010;
    s_rdata = {32'h1111_1111, 32'hBAD0_BAD0, 32'hCAFE_0001};
    step();
    s_ack = 3'b001;
    step();
    s_ack = '0;
    step();

    // Slave2 with minimum latency, then a new request accepted in the ack cycle.
    wb_stb = 1'b1; wb_addr = 32'h2000_0044;
    t0 = cyc;
    push(1'b0, 32'h5555_AAAA, t0 + 2);
    push(1'b0, 32'h0BAD_F00D, t0 + 4);
    sample();
    check("s2_s_stb", {29'b0, s_stb}, 32'b100);
    check("s2_s_addr", s_addr, 32'h0000_0044);
    step();
    wb_stb  = 1'b0;
    s_ack   = 3'b100;
    s_rdata = {32'h5555_AAAA, 32'h2222_2222, 32'h3333_3333};
    step();
    s_ack  = '0;
    wb_stb = 1'b1; wb_addr = 32'h0000_0200;
    sample();
    check("b2b_stall", {31'b0, wb_stall}, 32'd0);
    check("b2b_s_stb", {29'b0, s_stb}, 32'b001);
    step();
    wb_stb  = 1'b0;
    s_ack   = 3'b001;
    s_rdata = {32'h5555_AAAA, 32'h2222_2222, 32'h0BAD_F00D};
    step();
    s_ack = '0;
    step();

    // Silent slave.
    wb_stb = 1'b1; wb_addr = 32'h0000_0020;
    t0 = cyc;
`ifdef WB_BUS_TIMEOUT_EN
    push(1'b1, 32'hFFFF_FFFF, t0 + 5);
    step();
    wb_stb = 1'b0;
    for (int i = 1; i < 5; i++) begin
      sample();
      check("to_stall", {31'b0, wb_stall}, 32'd1);
      step();
    end
    step();
    step();
`else
    step();
    wb_stb = 1'b0;
    repeat (1000) step();
    sample();
    check("noto_still_busy", {31'b0, wb_stall}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif

    // Stall held 3 cycles with stb held; acceptance on the first unstalled cycle.
    wb_stb = 1'b1; wb_addr = 32'h0000_0030; s_stall = 3'b001;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stl_stall_mirror", {31'b0, wb_stall}, 32'd1);
      check("stl_s_stb_held", {29'b0, s_stb}, 32'b001);
      step();
    end
    s_stall = '0;
    t0 = cyc;
    push(1'b0, 32'h0000_0033, t0 + 2);
    sample();
    check("stl_accept_stall", {31'b0, wb_stall}, 32'd0);
    check("stl_accept_s_stb", {29'b0, s_stb}, 32'b001);
    step();
    wb_stb  = 1'b0;
    s_stall = 3'b001;
    s_ack   = 3'b001;
    s_rdata = {32'h1111_1111, 32'h2222_2222, 32'h0000_0033};
    sample();
    check("stl_one_pulse", {29'b0, s_stb}, 32'd0);
    step();
    s_ack = '0; s_stall = '0;
    step();

    // Reset in BUSY: outputs drop immediately, stale ack produces nothing.
    wb_stb = 1'b1; wb_addr = 32'h0000_0040;
    sample();
    check("rb_s_stb", {29'b0, s_stb}, 32'b001);
    step();
    wb_addr = 32'h0000_0044; s_stall = 3'b001;
    #2 rst_n = 1'b0;
    #1;
    check("rb_stall", {31'b0, wb_stall}, 32'd0);
    check("rb_s_stb_gated", {29'b0, s_stb}, 32'd0);
    check("rb_ack", {31'b0, wb_ack}, 32'd0);
    check("rb_err", {31'b0, wb_err}, 32'd0);
    check("rb_data", wb_data, 32'hFFFF_FFFF);
    step();
    step();
    rst_n = 1'b1;
    idle_inputs();
    s_ack   = 3'b001;
    s_rdata = {32'h1111_1111, 32'h2222_2222, 32'h4444_4444};
    step();
    s_ack = '0;
    step();
    wb_stb = 1'b1; wb_addr = 32'h0000_0050;
    t0 = cyc;
    push(1'b0, 32'h5050_5050, t0 + 2);
    step();
    wb_stb  = 1'b0;
    s_ack   = 3'b001;
    s_rdata = {32'h1111_1111, 32'h2222_2222, 32'h5050_5050};
    step();
    s_ack = '0;
    repeat (3) step();

    check("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
